// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: multiplier triplet to {neg, one, two} digit select.
module booth_r4_enc
  import booth_pkg::*;
(
  input  logic [2:0]   i_triplet,
  output booth_digit_t o_digit
);

  // 111 is -0; neg is cleared so the adder sees a plain zero
  always_comb begin
    o_digit = '0;
    unique case (i_triplet)
      3'b001, 3'b010: o_digit.one = 1'b1;
      3'b011:         o_digit.two = 1'b1;
      3'b100:         begin o_digit.neg = 1'b1; o_digit.two = 1'b1; end
      3'b101, 3'b110: begin o_digit.neg = 1'b1; o_digit.one = 1'b1; end
      default:        o_digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq.sv
// Iterative signed radix-4 Booth multiplier, one digit per cycle on a shared adder.
// Optional BOOTH_EARLY_EXIT_EN ends CALC once the remaining multiplier digits are all zero.
module booth_r4_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]       r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;

  booth_digit_t         w_digit;
  logic [2*WIDTH-1:0]   w_sel;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;

  // mcand shifts left by 2 and mplier right by 2 each cycle, so the
  // current digit is always at mplier[2:0] and needs no 2i shifter
  booth_r4_enc u_enc (
    .i_triplet (r_mplier[2:0]),
    .o_digit   (w_digit)
  );

  always_comb begin
    w_sel = '0;
    if (w_digit.two)
      w_sel = r_mcand << 1;
    else if (w_digit.one)
      w_sel = r_mcand;
    w_addend = w_digit.neg ? ~w_sel : w_sel;
    w_sum    = r_acc + w_addend + {{(2*WIDTH-1){1'b0}}, w_digit.neg};
  end

`ifdef BOOTH_EARLY_EXIT_EN
  assign w_last = (r_cnt == LAST_CNT) | (&r_mplier[WIDTH:2]) | ~(|r_mplier[WIDTH:2]);
`else
  assign w_last = (r_cnt == LAST_CNT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            r_mplier <= {b, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 2;
          r_mplier <= {{2{r_mplier[WIDTH]}}, r_mplier[WIDTH:2]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last)
            r_state <= DONE;
        end
        DONE: begin
          if (out_ready)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == CALC);
  assign out_valid = (r_state == DONE);
  assign product   = r_acc;

endmodule

// File: tb/tb_booth_r4_seq.sv
// Scoreboard bench for booth_r4_seq; latency expectations follow BOOTH_EARLY_EXIT_EN.
module tb_booth_r4_seq;

  localparam int WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               in_ready;
  logic               out_valid;
  logic               busy;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [31:0] expQ[$];

  // latency in clock edges from the accept edge to out_valid rising
  localparam int NUM_LAT = 4;
  logic [15:0] latA [NUM_LAT] = '{16'h0003, 16'h0001, 16'h1234, 16'h0021};
  logic [15:0] latB [NUM_LAT] = '{16'h0005, 16'h8000, 16'h0001, 16'hFFFF};
`ifdef BOOTH_EARLY_EXIT_EN
  int          latE [NUM_LAT] = '{2, 8, 1, 1};
`else
  int          latE [NUM_LAT] = '{8, 8, 8, 8};
`endif

  localparam int NUM_CORNER = 5;
  logic [15:0] ca [NUM_CORNER] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
  logic [15:0] cb [NUM_CORNER] = '{16'h8000, 16'h0001, 16'h8000, 16'h1234, 16'h7FFF};
  logic [31:0] ce [NUM_CORNER] = '{32'h40000000, 32'hFFFFFFFF, 32'hC0008000, 32'h00000000, 32'hC0008000};

  booth_r4_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refMul(input logic [15:0] x, input logic [15:0] y);
    longint px;
    px = longint'($signed(x)) * longint'($signed(y));
    return px[31:0];
  endfunction

  function automatic logic [31:0] popExp();
    if (expQ.size() == 0)
      return 32'hxxxxxxxx;
    return expQ.pop_front();
  endfunction

  function automatic logic [15:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // called at a negedge; returns at the negedge after the accept edge
  task automatic sendPair(input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] expVal, output bit ok);
    a = x;
    b = y;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok)
      expQ.push_back(expVal);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_product: got %h expected 00000000", product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    sendPair(16'd3, 16'd5, 32'h0000000F, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL basic_accept: got in_ready=0 expected 1");
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_busy: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    waitValid(n);
    checks++;
    if (n != latE[0]) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d expected %0d", n, latE[0]);
    end
    e = popExp();
    checks++;
    if (product !== e) begin
      errors++;
      $display("[TB] FAIL basic_product: got %h expected %h", product, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_pulse: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_LAT; i++) begin
      sendPair(latA[i], latB[i], refMul(latA[i], latB[i]), ok);
      waitValid(n);
      checks++;
      if (!ok || n != latE[i]) begin
        errors++;
        $display("[TB] FAIL latency_%0d: got accepted=%b edges=%0d expected 1 %0d", i, ok, n, latE[i]);
      end
      e = popExp();
      checks++;
      if (product !== e) begin
        errors++;
        $display("[TB] FAIL latency_product_%0d: got %h expected %h", i, product, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_corners();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_CORNER; i++) begin
      sendPair(ca[i], cb[i], ce[i], ok);
      waitValid(n);
      e = popExp();
      checks++;
      if (!ok || out_valid !== 1'b1 || product !== e) begin
        errors++;
        $display("[TB] FAIL corner_%0d: got valid=%b product=%h expected 1 %h", i, out_valid, product, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b0;
    sendPair(16'd1234, 16'hFDC9, refMul(16'd1234, 16'hFDC9), ok);
    waitValid(n);
    e = popExp();
    checks++;
    if (!ok || out_valid !== 1'b1 || product !== e) begin
      errors++;
      $display("[TB] FAIL bp_first: got valid=%b product=%h expected 1 %h", out_valid, product, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d: got valid=%b in_ready=%b product=%h expected 1 0 %h",
                 i, out_valid, in_ready, product, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    sendPair(16'd1000, 16'd1000, refMul(16'd1000, 16'd1000), ok);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_precond: got busy=%b expected 1", busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_calc: got in_ready=%b out_valid=%b busy=%b product=%h expected 1 0 0 00000000",
               in_ready, out_valid, busy, product);
    end
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sendPair(16'd7, 16'hFFF7, 32'hFFFFFFC1, ok);
    waitValid(n);
    e = popExp();
    checks++;
    if (!ok || out_valid !== 1'b1 || product !== e) begin
      errors++;
      $display("[TB] FAIL rst_next_txn: got valid=%b product=%h expected 1 %h", out_valid, product, e);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    bit ok;
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    sendPair(16'd3, 16'd5, 32'h0000000F, ok);
    a = 16'h7FFF;
    b = 16'h7FFF;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    waitValid(n);
    e = popExp();
    checks++;
    if (!ok || out_valid !== 1'b1 || product !== e) begin
      errors++;
      $display("[TB] FAIL ignore_product: got valid=%b product=%h expected 1 %h", out_valid, product, e);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL ignore_idle: got in_ready=%b busy=%b pending=%0d expected 1 0 0",
               in_ready, busy, expQ.size());
    end
  endtask

  task automatic test_random();
    localparam int N = 1500;
    int got = 0;
    fork
      begin
        logic [15:0] x;
        logic [15:0] y;
        bit ok;
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          x = pickOperand();
          y = pickOperand();
          sendPair(x, y, refMul(x, y), ok);
          if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL random_accept_%0d: got no accept expected accept", i);
            break;
          end
        end
      end
      begin
        int cyc = 0;
        logic [31:0] e;
        while (got < N && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            e = popExp();
            checks++;
            if (product !== e) begin
              errors++;
              $display("[TB] FAIL random_product_%0d: got %h expected %h", got, product, e);
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    checks++;
    if (got != N || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d results pending=%0d expected %0d results pending=0",
               got, expQ.size(), N);
    end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] booth_r4_seq bench start");
    test_reset();
    test_basic();
    test_latency();
    test_corners();
    test_backpressure();
    test_reset_mid_calc();
    test_ignore_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
